// File: rtl/divisor_top.sv
// Sequential signed divider: restoring division on operand magnitudes,
// one quotient bit per clock, followed by a single sign-correction cycle.
module divisor_top #(
   parameter int tamanyo = 32
) (
   input  logic               CLK,
   input  logic               RSTn,
   input  logic               START,
   input  logic [tamanyo-1:0] NUMERADOR,
   input  logic [tamanyo-1:0] DENOMINADOR,
   output logic [tamanyo-1:0] COC,
   output logic [tamanyo-1:0] RES,
   output logic               DONE
);

   localparam int CW = $clog2(tamanyo + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_reg, state_next;
   // dvd_reg shifts dividend bits out of the top while quotient bits enter at the bottom
   logic [tamanyo-1:0] dvd_reg, dvd_next;
   logic [tamanyo-1:0] dvs_reg, dvs_next;
   logic [tamanyo:0]   rem_reg, rem_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic               neg_q_reg, neg_q_next;
   logic               neg_r_reg, neg_r_next;
   logic               dz_reg, dz_next;
   logic [tamanyo-1:0] coc_reg, coc_next;
   logic [tamanyo-1:0] res_reg, res_next;
   logic               done_reg, done_next;

   logic [tamanyo+1:0] shifted;
   logic [tamanyo:0]   diff;
   logic               q_bit;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_reg <= IDLE;
         dvd_reg   <= '0;
         dvs_reg   <= '0;
         rem_reg   <= '0;
         cnt_reg   <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         dz_reg    <= 1'b0;
         coc_reg   <= '0;
         res_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         dvd_reg   <= dvd_next;
         dvs_reg   <= dvs_next;
         rem_reg   <= rem_next;
         cnt_reg   <= cnt_next;
         neg_q_reg <= neg_q_next;
         neg_r_reg <= neg_r_next;
         dz_reg    <= dz_next;
         coc_reg   <= coc_next;
         res_reg   <= res_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      dvd_next   = dvd_reg;
      dvs_next   = dvs_reg;
      rem_next   = rem_reg;
      cnt_next   = cnt_reg;
      neg_q_next = neg_q_reg;
      neg_r_next = neg_r_reg;
      dz_next    = dz_reg;
      coc_next   = coc_reg;
      res_next   = res_reg;
      done_next  = 1'b0;

      shifted = {rem_reg, dvd_reg[tamanyo-1]};
      q_bit   = (shifted >= {2'b00, dvs_reg});
      diff    = shifted[tamanyo:0] - {1'b0, dvs_reg};

      case (state_reg)
         IDLE: begin
            if (START) begin
               neg_r_next = NUMERADOR[tamanyo-1];
               neg_q_next = NUMERADOR[tamanyo-1] ^ DENOMINADOR[tamanyo-1];
               dz_next    = (DENOMINADOR == '0);
               dvd_next   = NUMERADOR[tamanyo-1] ? -NUMERADOR : NUMERADOR;
               dvs_next   = DENOMINADOR[tamanyo-1] ? -DENOMINADOR : DENOMINADOR;
               rem_next   = '0;
               cnt_next   = '0;
               state_next = CALC;
            end
         end
         CALC: begin
            rem_next = q_bit ? diff : shifted[tamanyo:0];
            dvd_next = {dvd_reg[tamanyo-2:0], q_bit};
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(tamanyo - 1)) begin
               state_next = FIX;
            end
         end
         FIX: begin
            // a zero divisor leaves an all-ones magnitude; keep it unsigned regardless of signs
            if (dz_reg) begin
               coc_next = '1;
            end else begin
               coc_next = neg_q_reg ? -dvd_reg : dvd_reg;
            end
            res_next   = neg_r_reg ? -rem_reg[tamanyo-1:0] : rem_reg[tamanyo-1:0];
            done_next  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign COC  = coc_reg;
   assign RES  = res_reg;
   assign DONE = done_reg;

endmodule

// File: tb/tb_divisor_top.sv
// Self-checking bench for divisor_top: directed corners plus randomized
// back-to-back divisions checked against an arithmetic reference.
module tb_divisor_top;

   localparam int W = 32;

   logic         CLK = 1'b0;
   logic         RSTn = 1'b0;
   logic         START = 1'b0;
   logic [W-1:0] NUMERADOR = '0;
   logic [W-1:0] DENOMINADOR = '0;
   logic [W-1:0] COC;
   logic [W-1:0] RES;
   logic         DONE;

   int errors = 0;
   int checks = 0;

   divisor_top #(.tamanyo(W)) dut (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .START       (START),
      .NUMERADOR   (NUMERADOR),
      .DENOMINADOR (DENOMINADOR),
      .COC         (COC),
      .RES         (RES),
      .DONE        (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain signed arithmetic (truncating division, remainder follows dividend)
   function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      longint sn, sd;
      sn = longint'(signed'(n));
      sd = longint'(signed'(d));
      if (sd == 0) begin
         q = '1;
         r = n;
      end else begin
         q = W'(sn / sd);
         r = W'(sn % sd);
      end
   endfunction

   // Model state: one operation in flight, accepted only when not busy
   int           busy = 0;
   logic         exp_done = 1'b0;
   logic [W-1:0] pend_n = '0, pend_d = '0, pend_q = '0, pend_r = '0;
   logic [W-1:0] last_coc = '0, last_res = '0, cur_n = '0, cur_d = '0;

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         busy     = 0;
         exp_done = 1'b0;
         last_coc = '0;
         last_res = '0;
      end else begin
         exp_done = 1'b0;
         if (busy > 0) begin
            busy--;
            if (busy == 0) begin
               exp_done = 1'b1;
               last_coc = pend_q;
               last_res = pend_r;
               cur_n    = pend_n;
               cur_d    = pend_d;
            end
         end else if (START) begin
            pend_n = NUMERADOR;
            pend_d = DENOMINADOR;
            ref_div(NUMERADOR, DENOMINADOR, pend_q, pend_r);
            busy = W + 1;
         end
      end
   end

   // Compare process: every cycle, DONE timing and held results against the model
   always @(negedge CLK) begin
      logic [W-1:0] prod;
      longint ar, ad;
      chk("done", W'(DONE), W'(exp_done));
      chk("coc", COC, last_coc);
      chk("res", RES, last_res);
      if (exp_done && RSTn && cur_d != '0) begin
         prod = COC * cur_d + RES;
         chk("invariant", prod, cur_n);
         ar = longint'(signed'(RES));
         ad = longint'(signed'(cur_d));
         if (ar < 0) ar = -ar;
         if (ad < 0) ad = -ad;
         chk("rem_mag", W'(ar < ad), W'(1));
      end
   end

   task automatic op_start(input logic [W-1:0] n, input logic [W-1:0] d);
      START       = 1'b1;
      NUMERADOR   = n;
      DENOMINADOR = d;
      @(negedge CLK);
      START       = 1'b0;
      NUMERADOR   = $urandom;
      DENOMINADOR = $urandom;
   endtask

   task automatic wait_done(output int cnt);
      cnt = 0;
      do begin
         @(negedge CLK);
         cnt++;
      end while (!DONE && cnt < W + 10);
      if (!DONE) begin
         chk("done_timeout", W'(DONE), W'(1));
      end
   endtask

   task automatic dir(input string name, input logic [W-1:0] n, input logic [W-1:0] d,
                      input logic [W-1:0] ec, input logic [W-1:0] er);
      int cnt;
      op_start(n, d);
      wait_done(cnt);
      chk({name, "_coc"}, COC, ec);
      chk({name, "_res"}, RES, er);
      $display("op %s: %h / %h -> coc=%h res=%h after %0d cycles", name, n, d, COC, RES, cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int cnt;
      logic [W-1:0] n, d;

      repeat (3) @(negedge CLK);
      chk("rst_coc", COC, '0);
      chk("rst_res", RES, '0);
      chk("rst_done", W'(DONE), '0);
      RSTn = 1'b1;
      @(negedge CLK);

      op_start(32'd100, 32'd7);
      wait_done(cnt);
      chk("lat_100_7", W'(cnt), W'(W + 1));
      chk("d100_7_coc", COC, 32'h0000000E);
      chk("d100_7_res", RES, 32'd2);
      @(negedge CLK);
      chk("done_one_cycle", W'(DONE), '0);

      dir("m100_7",  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE);
      dir("100_m7",  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
      dir("m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE);
      dir("ovf",     32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
      dir("min_1",   32'h80000000, 32'd1,        32'h80000000, 32'd0);
      dir("div0",    32'd5,        32'd0,        32'hFFFFFFFF, 32'd5);
      dir("m5_div0", 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB);
      dir("zero_9",  32'd0,        32'd9,        32'd0,        32'd0);

      // Busy protection: a second START mid-calculation must be ignored
      op_start(32'd1000, 32'd10);
      repeat (5) @(negedge CLK);
      START = 1'b1; NUMERADOR = 32'd7; DENOMINADOR = 32'd7;
      @(negedge CLK);
      START = 1'b0; NUMERADOR = $urandom; DENOMINADOR = $urandom;
      wait_done(cnt);
      chk("busy_coc", COC, 32'd100);
      chk("busy_res", RES, 32'd0);
      $display("op busy: 1000 / 10 -> coc=%h res=%h", COC, RES);
      repeat (2 * W) @(negedge CLK);

      // Asynchronous reset in the middle of an operation
      op_start(32'd50, 32'd3);
      repeat (8) @(negedge CLK);
      #2 RSTn = 1'b0;
      #1;
      chk("arst_coc", COC, '0);
      chk("arst_res", RES, '0);
      chk("arst_done", W'(DONE), '0);
      $display("op reset mid-calc: coc=%h res=%h done=%b", COC, RES, DONE);
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      repeat (2 * W) @(negedge CLK);
      dir("post_rst", 32'd50, 32'd3, 32'd16, 32'd2);

      // Random regression, each new START issued in the DONE cycle
      for (int i = 0; i < 1500; i++) begin
         n = $urandom;
         if (i % 2 == 0) begin
            d = $urandom;
         end else begin
            d = 32'($urandom_range(1, 300));
            if ($urandom_range(0, 1) == 1) d = -d;
         end
         if (d == '0) d = 32'd1;
         op_start(n, d);
         wait_done(cnt);
         chk("rand_latency", W'(cnt), W'(W + 1));
         if (i % 100 == 0) begin
            $display("op rand %0d: %h / %h -> coc=%h res=%h", i, n, d, COC, RES);
         end
      end

      repeat (3) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
